// File: rtl/instr_type.sv
// instr_type: shared load kind/exception types and the load legality check
package instr_type;

    typedef enum logic [2:0] {
        lk_lb,
        lk_lh,
        lk_lw,
        lk_lbu,
        lk_lhu,
        lk_invalid
    } load_kind_t;

    typedef enum logic [1:0] {
        le_none,
        le_misaligned,
        le_illegal
    } load_exc_t;

    function automatic load_exc_t load_check(input load_kind_t k, input logic [1:0] a);
        return k == lk_invalid ? le_illegal :
               (((k == lk_lh || k == lk_lhu) && a[0]) || (k == lk_lw && a != 2'b00)) ? le_misaligned :
               le_none;
    endfunction

endpackage

// File: rtl/load_extend.sv
// load_extend: pick the addressed byte/halfword from a read word and extend it
module load_extend
    import instr_type::*;
#(
    parameter int XLEN = 32
) (
    input  load_kind_t        kind,
    input  logic [1:0]        off,
    input  logic [XLEN-1:0]   rdata,
    output logic [XLEN-1:0]   data
);

    logic [7:0]  b;
    logic [15:0] h;

    // Little-endian lane select, then sign/zero extension by load kind
    always_comb begin
        b = rdata[8*off +: 8];
        h = rdata[16*off[1] +: 16];
        data = kind == lk_lb  ? {{(XLEN-8){b[7]}}, b} :
               kind == lk_lbu ? {{(XLEN-8){1'b0}}, b} :
               kind == lk_lh  ? {{(XLEN-16){h[15]}}, h} :
               kind == lk_lhu ? {{(XLEN-16){1'b0}}, h} :
               rdata;
    end

endmodule

// File: rtl/load_unit.sv
// load_unit: single-outstanding load FSM with alignment checks and result extension
module load_unit
    import instr_type::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  load_kind_t        in_kind,
    input  logic [XLEN-1:0]   in_addr,
    input  logic [4:0]        in_rd,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [XLEN-1:0]   mem_addr,
    input  logic              mem_resp_valid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4:0]        out_rd,
    output logic [XLEN-1:0]   out_data,
    output load_exc_t         out_exc
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]      state;
    logic            ready_q;
    load_kind_t      kind_q;
    logic [XLEN-1:0] addr_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] data_q;
    load_exc_t       exc_q;
    load_exc_t       exc;
    logic [XLEN-1:0] ext;
    logic            accept;

    load_extend #(.XLEN(XLEN)) u_ext (
        .kind  (kind_q),
        .off   (addr_q[1:0]),
        .rdata (mem_rdata),
        .data  (ext)
    );

    assign exc           = load_check(in_kind, in_addr[1:0]);
    assign accept        = state == S_IDLE && ready_q && in_valid;
    assign in_ready      = ready_q;
    assign mem_req_valid = state == S_REQ;
    assign out_valid     = state == S_DONE;
    assign mem_addr      = {addr_q[XLEN-1:2], 2'b00};
    assign out_rd        = rd_q;
    assign out_data      = data_q;
    assign out_exc       = exc_q;

    // in_ready is registered so it stays low through reset and has no input path
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            ready_q <= 1'b0;
            kind_q  <= lk_lb;
            addr_q  <= '0;
            rd_q    <= '0;
            data_q  <= '0;
            exc_q   <= le_none;
        end else begin
            ready_q <= (state == S_IDLE && !accept) || (state == S_DONE && out_ready);
            case (state)
                S_IDLE: if (accept) begin
                    kind_q <= in_kind;
                    addr_q <= in_addr;
                    rd_q   <= in_rd;
                    exc_q  <= exc;
                    data_q <= '0;
                    state  <= exc == le_none ? S_REQ : S_DONE;
                end
                S_REQ:  if (mem_req_ready) state <= S_WAIT;
                S_WAIT: if (mem_resp_valid) begin
                    data_q <= ext;
                    state  <= S_DONE;
                end
                default: if (out_ready) state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: directed self-checking bench for load_unit
module tb_load_unit;
    import instr_type::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    load_kind_t  in_kind;
    logic [31:0] in_addr;
    logic [4:0]  in_rd;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    load_exc_t   out_exc;

    int errors = 0;
    int checks = 0;
    int handshakes = 0;
    int mreq_cycles = 0;
    int h0;
    int m0;

    load_unit #(.XLEN(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_kind        (in_kind),
        .in_addr        (in_addr),
        .in_rd          (in_rd),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_rd         (out_rd),
        .out_data       (out_data),
        .out_exc        (out_exc)
    );

    always #5 clk = ~clk;

    // Count delivered results and issued memory request cycles
    always @(posedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) handshakes <= handshakes + 1;
        if (mem_req_valid === 1'b1) mreq_cycles <= mreq_cycles + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_fast(input string tag, input load_kind_t k, input logic [31:0] a,
                            input logic [4:0] rd, input logic [31:0] rdat, input logic [31:0] exp);
        in_valid = 1'b1;
        in_kind = k;
        in_addr = a;
        in_rd = rd;
        mem_req_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk({tag, "_req"}, 32'(mem_req_valid), 32'd1);
        chk({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
        chk({tag, "_rdy_busy"}, 32'(in_ready), 32'd0);
        step();
        mem_resp_valid = 1'b1;
        mem_rdata = rdat;
        step();
        mem_resp_valid = 1'b0;
        mem_rdata = 32'h0;
        chk({tag, "_ovalid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, out_data, exp);
        chk({tag, "_exc"}, 32'(out_exc), 32'(le_none));
        chk({tag, "_rd"}, 32'(out_rd), 32'(rd));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_idle"}, 32'(out_valid), 32'd0);
        chk({tag, "_irdy"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 1'b0;
        in_kind = lk_lb;
        in_addr = 32'h0;
        in_rd = 5'd0;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata = 32'h0;
        out_ready = 1'b0;
        step();
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mem_req", 32'(mem_req_valid), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_out_rd", 32'(out_rd), 32'd0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_exc", 32'(out_exc), 32'(le_none));
        rst = 1'b1;
        step();
        chk("post_rst_ready", 32'(in_ready), 32'd1);

        run_fast("lb", lk_lb, 32'h0000_1003, 5'd3, 32'h80FF_0000, 32'hFFFF_FF80);
        run_fast("lhu", lk_lhu, 32'h0000_2002, 5'd4, 32'hBEEF_1234, 32'h0000_BEEF);
        run_fast("lh", lk_lh, 32'h0000_2002, 5'd6, 32'hBEEF_1234, 32'hFFFF_BEEF);
        run_fast("lbu", lk_lbu, 32'h0000_1001, 5'd7, 32'h1234_5678, 32'h0000_0056);
        run_fast("lh_lo", lk_lh, 32'h0000_0000, 5'd8, 32'h0000_8001, 32'hFFFF_8001);
        run_fast("lw", lk_lw, 32'h0000_4000, 5'd9, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        m0 = mreq_cycles;
        in_valid = 1'b1;
        in_kind = lk_lw;
        in_addr = 32'h0000_3001;
        in_rd = 5'd10;
        step();
        in_valid = 1'b0;
        chk("mis_ovalid_t1", 32'(out_valid), 32'd1);
        chk("mis_exc", 32'(out_exc), 32'(le_misaligned));
        chk("mis_data", out_data, 32'h0);
        chk("mis_no_req", 32'(mem_req_valid), 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("mis_req_count", 32'(mreq_cycles - m0), 32'd0);

        h0 = handshakes;
        mem_req_ready = 1'b0;
        in_valid = 1'b1;
        in_kind = lk_lw;
        in_addr = 32'h0000_4000;
        in_rd = 5'd11;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_req", 32'(mem_req_valid), 32'd1);
            chk("stall_addr", mem_addr, 32'h0000_4000);
            chk("stall_irdy", 32'(in_ready), 32'd0);
            step();
        end
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("wait_ovalid", 32'(out_valid), 32'd0);
            chk("wait_addr", mem_addr, 32'h0000_4000);
            step();
        end
        mem_resp_valid = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        step();
        mem_rdata = 32'h5555_AAAA;
        for (int i = 0; i < 2; i++) begin
            chk("hold_ovalid", 32'(out_valid), 32'd1);
            chk("hold_data", out_data, 32'hCAFE_F00D);
            chk("hold_rd", 32'(out_rd), 32'd11);
            chk("hold_irdy", 32'(in_ready), 32'd0);
            step();
        end
        mem_resp_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("stall_done_ovalid", 32'(out_valid), 32'd0);
        chk("stall_done_irdy", 32'(in_ready), 32'd1);
        step();
        chk("stall_one_result", 32'(handshakes - h0), 32'd1);

        mem_req_ready = 1'b1;
        in_valid = 1'b1;
        in_kind = lk_lw;
        in_addr = 32'h0000_5000;
        in_rd = 5'd12;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("midrst_mem_req", 32'(mem_req_valid), 32'd0);
        chk("midrst_irdy", 32'(in_ready), 32'd0);
        rst = 1'b1;
        mem_resp_valid = 1'b1;
        mem_rdata = 32'h1111_1111;
        step();
        mem_resp_valid = 1'b0;
        chk("late_resp_ovalid", 32'(out_valid), 32'd0);
        chk("late_resp_data", out_data, 32'h0);
        step();
        chk("late_resp_ovalid2", 32'(out_valid), 32'd0);
        chk("late_resp_irdy", 32'(in_ready), 32'd1);
        run_fast("after_rst", lk_lbu, 32'h0000_5002, 5'd13, 32'h00AB_0000, 32'h0000_00AB);

        m0 = mreq_cycles;
        in_valid = 1'b1;
        in_kind = lk_invalid;
        in_addr = 32'h0000_6000;
        in_rd = 5'd5;
        step();
        in_valid = 1'b0;
        chk("ill_ovalid", 32'(out_valid), 32'd1);
        chk("ill_exc", 32'(out_exc), 32'(le_illegal));
        chk("ill_rd", 32'(out_rd), 32'd5);
        chk("ill_data", out_data, 32'h0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("ill_req_count", 32'(mreq_cycles - m0), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
